// File: rtl/ls_ctrl_unit_if.sv
// Store/load control bus between the pipeline (master) and the
// load/store control unit (slave). The master supplies the decoded
// instruction fields and store operand. The slave returns the
// lane-aligned store data, byte enables, load format and alignment flag.
interface ls_ctrl_unit_if;
  logic [2:0]  func3;
  logic [1:0]  address;
  logic [31:0] rdata2;
  logic [31:0] wdata_mem;
  logic [3:0]  mask;
  logic [2:0]  load_ctrl;
  logic        misaligned;

  modport master (
    output func3,
    output address,
    output rdata2,
    input  wdata_mem,
    input  mask,
    input  load_ctrl,
    input  misaligned
  );

  modport slave (
    input  func3,
    input  address,
    input  rdata2,
    output wdata_mem,
    output mask,
    output load_ctrl,
    output misaligned
  );
endinterface

// File: rtl/ls_ctrl_unit.sv
// Load/store control unit.
// Decodes the access width from funct3 and the byte offset. Produces
// lane-aligned store data, byte-write enables, the load-format code and
// a misalignment flag. All outputs are registered with one cycle of
// latency. The output registers are the only state in the block.
module ls_ctrl_unit (
  input  logic         clk,
  input  logic         rst,
  ls_ctrl_unit_if.slave bus
);

  typedef enum logic [1:0] {
    WIDTH_BYTE    = 2'b00,
    WIDTH_HALF    = 2'b01,
    WIDTH_WORD    = 2'b10,
    WIDTH_INVALID = 2'b11
  } width_e;

  width_e      width;
  logic [31:0] wdata_d;
  logic [3:0]  mask_d;
  logic        misaligned_d;

  // Combinational decode of width/offset into lane enables and aligned data.
  // func3[2] (signedness) only matters to the load path, so it is ignored here.
  always_comb begin
    width        = width_e'(bus.func3[1:0]);
    wdata_d      = 32'h0;
    mask_d       = 4'b0000;
    misaligned_d = 1'b0;
    case (width)
      WIDTH_BYTE: begin
        mask_d  = 4'b0001 << bus.address;
        wdata_d = {24'h0, bus.rdata2[7:0]} << {bus.address, 3'b000};
      end
      WIDTH_HALF: begin
        if (bus.address[0]) begin
          misaligned_d = 1'b1;
        end else if (bus.address[1]) begin
          mask_d  = 4'b1100;
          wdata_d = {bus.rdata2[15:0], 16'h0};
        end else begin
          mask_d  = 4'b0011;
          wdata_d = {16'h0, bus.rdata2[15:0]};
        end
      end
      WIDTH_WORD: begin
        if (bus.address == 2'b00) begin
          mask_d  = 4'b1111;
          wdata_d = bus.rdata2;
        end else begin
          misaligned_d = 1'b1;
        end
      end
      WIDTH_INVALID: begin
        // No lanes are enabled. This is not an alignment fault.
        mask_d = 4'b0000;
      end
    endcase
  end

  // Output registers. Reset has priority and discards any pending capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.wdata_mem  <= 32'h0;
      bus.mask       <= 4'b0000;
      bus.load_ctrl  <= 3'b000;
      bus.misaligned <= 1'b0;
    end else begin
      bus.wdata_mem  <= wdata_d;
      bus.mask       <= mask_d;
      bus.load_ctrl  <= bus.func3;
      bus.misaligned <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_ls_ctrl_unit.sv
// Directed bench for ls_ctrl_unit: a table of store/load vectors plus
// hand-written reset sequences.
module tb_ls_ctrl_unit;

  logic clk;
  logic rst;

  ls_ctrl_unit_if bus_i ();

  ls_ctrl_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  func3;
    logic [1:0]  address;
    logic [31:0] rdata2;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_mask;
    logic [2:0]  exp_lc;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];
  int total;
  int bad;

  function automatic vec_t mk(input logic [2:0] f, input logic [1:0] a,
                              input logic [31:0] d, input logic [31:0] w,
                              input logic [3:0] m, input logic [2:0] lc,
                              input logic mis);
    vec_t v;
    v.func3 = f; v.address = a; v.rdata2 = d;
    v.exp_wdata = w; v.exp_mask = m; v.exp_lc = lc; v.exp_mis = mis;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] w,
                       input logic [3:0] m, input logic [2:0] lc,
                       input logic mis);
    total++;
    if (bus_i.wdata_mem !== w) begin
      bad++;
      $display("FAIL %s wdata_mem got=%h exp=%h", name, bus_i.wdata_mem, w);
    end
    total++;
    if (bus_i.mask !== m) begin
      bad++;
      $display("FAIL %s mask got=%b exp=%b", name, bus_i.mask, m);
    end
    total++;
    if (bus_i.load_ctrl !== lc) begin
      bad++;
      $display("FAIL %s load_ctrl got=%b exp=%b", name, bus_i.load_ctrl, lc);
    end
    total++;
    if (bus_i.misaligned !== mis) begin
      bad++;
      $display("FAIL %s misaligned got=%b exp=%b", name, bus_i.misaligned, mis);
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [1:0] a,
                       input logic [31:0] d);
    bus_i.func3   = f;
    bus_i.address = a;
    bus_i.rdata2  = d;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs.push_back(mk(3'b000, 2'd0, 32'hA1B2C3D4, 32'h000000D4, 4'b0001, 3'b000, 1'b0));
    vecs.push_back(mk(3'b000, 2'd1, 32'hA1B2C3D4, 32'h0000D400, 4'b0010, 3'b000, 1'b0));
    vecs.push_back(mk(3'b000, 2'd2, 32'hA1B2C3D4, 32'h00D40000, 4'b0100, 3'b000, 1'b0));
    vecs.push_back(mk(3'b000, 2'd3, 32'hA1B2C3D4, 32'hD4000000, 4'b1000, 3'b000, 1'b0));
    vecs.push_back(mk(3'b001, 2'd0, 32'h1234ABCD, 32'h0000ABCD, 4'b0011, 3'b001, 1'b0));
    vecs.push_back(mk(3'b001, 2'd2, 32'h1234ABCD, 32'hABCD0000, 4'b1100, 3'b001, 1'b0));
    vecs.push_back(mk(3'b001, 2'd1, 32'h1234ABCD, 32'h00000000, 4'b0000, 3'b001, 1'b1));
    vecs.push_back(mk(3'b001, 2'd3, 32'h1234ABCD, 32'h00000000, 4'b0000, 3'b001, 1'b1));
    vecs.push_back(mk(3'b010, 2'd0, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 3'b010, 1'b0));
    vecs.push_back(mk(3'b010, 2'd3, 32'hDEADBEEF, 32'h00000000, 4'b0000, 3'b010, 1'b1));
    vecs.push_back(mk(3'b010, 2'd1, 32'hDEADBEEF, 32'h00000000, 4'b0000, 3'b010, 1'b1));
    vecs.push_back(mk(3'b010, 2'd2, 32'hDEADBEEF, 32'h00000000, 4'b0000, 3'b010, 1'b1));
    vecs.push_back(mk(3'b100, 2'd2, 32'hA1B2C3D4, 32'h00D40000, 4'b0100, 3'b100, 1'b0));
    vecs.push_back(mk(3'b101, 2'd2, 32'h1234ABCD, 32'hABCD0000, 4'b1100, 3'b101, 1'b0));
    vecs.push_back(mk(3'b101, 2'd1, 32'h1234ABCD, 32'h00000000, 4'b0000, 3'b101, 1'b1));
    vecs.push_back(mk(3'b110, 2'd0, 32'h55AA33CC, 32'h55AA33CC, 4'b1111, 3'b110, 1'b0));
    vecs.push_back(mk(3'b111, 2'd0, 32'hFFFFFFFF, 32'h00000000, 4'b0000, 3'b111, 1'b0));
    vecs.push_back(mk(3'b011, 2'd1, 32'hFFFFFFFF, 32'h00000000, 4'b0000, 3'b011, 1'b0));
    vecs.push_back(mk(3'b000, 2'd2, 32'h000000FF, 32'h00FF0000, 4'b0100, 3'b000, 1'b0));

    // Reset state, with busy inputs present during the reset edge.
    rst = 1'b0;
    drive(3'b010, 2'd0, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("reset", 32'h0, 4'b0000, 3'b000, 1'b0);
    @(negedge clk);

    // The first edge with rst=1 captures the inputs present at that edge.
    rst = 1'b1;
    drive(3'b001, 2'd2, 32'h1234ABCD);
    @(posedge clk); #1;
    check("first_after_reset", 32'hABCD0000, 4'b1100, 3'b001, 1'b0);

    // Table-driven stream. A new vector is applied every cycle and checked one edge later.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].func3, vecs[i].address, vecs[i].rdata2);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), vecs[i].exp_wdata, vecs[i].exp_mask,
            vecs[i].exp_lc, vecs[i].exp_mis);
    end

    // Mid-stream reset: the pending capture is discarded, then the stream resumes.
    @(negedge clk);
    drive(3'b000, 2'd3, 32'hA1B2C3D4);
    @(posedge clk); #1;
    check("pre_reset", 32'hD4000000, 4'b1000, 3'b000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(3'b010, 2'd0, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("mid_reset", 32'h0, 4'b0000, 3'b000, 1'b0);
    @(negedge clk);
    drive(3'b111, 2'd1, 32'hCAFEF00D);
    @(posedge clk); #1;
    check("held_reset", 32'h0, 4'b0000, 3'b000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    drive(3'b100, 2'd1, 32'h000000A5);
    @(posedge clk); #1;
    check("resume", 32'h0000A500, 4'b0010, 3'b100, 1'b0);
    @(negedge clk);
    drive(3'b010, 2'd0, 32'h01234567);
    @(posedge clk); #1;
    check("resume2", 32'h01234567, 4'b1111, 3'b010, 1'b0);

    // Outputs hold until the next edge.
    @(negedge clk);
    total++;
    if (bus_i.wdata_mem !== 32'h01234567) begin
      bad++;
      $display("FAIL hold wdata_mem got=%h exp=%h", bus_i.wdata_mem, 32'h01234567);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
